// File: rtl/muldiv_sequencer_if.sv
// HI/LO unit handshake bundle between the EX stage (master) and the mult/div sequencer (slave).
// Latency: none, wires only.
// Backpressure: busy from the slave stalls the EX stage; start is only honoured while busy is low.
// Ports: start/op/a/b/flush flow master->slave; busy/done/hi/lo/div_by_zero flow slave->master.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit: radix-2 shift-add multiply and restoring divide for mult/multu/div/divu.
// Latency: done pulses WIDTH+2 cycles after the start edge; a zero divisor completes after 2 cycles.
// Backpressure: busy is high while an op is in flight; start is ignored until busy drops, no queueing.
// Ports: clk, rst (async, active-high); bus = muldiv_sequencer_if.slave (start/op/a/b/flush in,
//        busy/done/hi/lo/div_by_zero out). op: 00 mult, 01 multu, 10 div, 11 divu.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;   // op class latched at acceptance
  logic               sa_q;       // dividend sign, drives remainder sign
  logic               neg_q;      // sA ^ sB, drives product/quotient sign
  logic               dz_q;       // zero divisor seen at acceptance
  logic               dbz_prev;   // flag value before the op, restored on flush
  logic [WIDTH-1:0]   opnd;       // |multiplicand| or |divisor|
  // Multiply: {product_hi, product_lo/multiplier}. Divide: {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0] acc;

  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

  // Operand conditioning at issue. -2^(WIDTH-1) negates to itself, which
  // is exactly its magnitude when read as unsigned.
  logic             in_div;
  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Datapath for one iteration and for the final sign fix.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    in_div    = bus.op[1];
    in_signed = ~bus.op[0];
    a_neg     = in_signed & bus.a[WIDTH-1];
    b_neg     = in_signed & bus.b[WIDTH-1];
    a_abs     = a_neg ? -bus.a : bus.a;
    b_abs     = b_neg ? -bus.b : bus.b;

    // Add the multiplicand into the upper half when the current multiplier
    // bit (acc LSB) is set; the carry lands in bit WIDTH and is shifted in.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};

    // Restoring step: remainder picks up the next dividend bit (MSB of the
    // low half); a clear borrow bit means the trial subtraction stays.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    q_bit     = ~div_diff[WIDTH];

    prod      = neg_q ? -acc : acc;
    quot      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      dbz_prev <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Flush squashes a start issued in the same cycle.
          if (bus.start && !bus.flush) begin
            is_div_q <= in_div;
            sa_q     <= a_neg;
            neg_q    <= a_neg ^ b_neg;
            dz_q     <= in_div && (bus.b == '0);
            cnt      <= '0;
            dbz_prev <= dbz_q;
            dbz_q    <= 1'b0;
            opnd     <= in_div ? b_abs : a_abs;
            acc      <= {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
            busy_q   <= 1'b1;
            state    <= (in_div && (bus.b == '0)) ? FIX : RUN;
          end
        end

        RUN: begin
          if (bus.flush) begin
            dbz_q  <= dbz_prev;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            if (is_div_q) begin
              acc <= {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                      acc[WIDTH-2:0], q_bit};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= FIX;
            end
          end
        end

        FIX: begin
          if (bus.flush) begin
            dbz_q <= dbz_prev;
          end else begin
            if (dz_q) begin
              dbz_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem;
              lo_q <= quot;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, hand-written corner sequences, random ops.
// Expected results are queued at issue and popped when done pulses.
// Done latency is counted as the index of the first edge after the start edge that sees done high.
module tb_muldiv_sequencer;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          busy;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          busy;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_tot;
  exp_t sb_q[$];
  logic [31:0] mhi;
  logic [31:0] mlo;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  // Reference model, independent of the iterative datapath.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl);
    exp_t e;
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    e.dbz = 1'b0; e.lat = 34; e.busy = 33;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    e.hi = ph; e.lo = pl;
    if (op[1] && b == 32'h0) begin
      e.dbz = 1'b1; e.lat = 2; e.busy = 1;
    end else begin
      case (op)
        MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
        MULTU: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
        DIV:   begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; end
        default: begin uq = ua / ub; ur = ua % ub; e.hi = ur[31:0]; e.lo = uq[31:0]; end
      endcase
    end
    return e;
  endfunction

  // Called at a negedge; drives start for one cycle, then scrambles the
  // operands to show they are not used after acceptance.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
  endtask

  // Called just after the start edge; returns at the negedge of the done cycle.
  task automatic wait_done(input string nm);
    exp_t e;
    int   n, bc;
    bit   seen;
    n = 1; bc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin seen = 1'b1; break; end
      n++;
    end
    if (sb_q.size() == 0) begin
      n_tot++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", nm);
      return;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      n_tot++;
      $display("FAIL %s_timeout: got no done within 100 cycles expected done", nm);
      return;
    end
    chk({nm, "_lat"}, n, e.lat);
    chk({nm, "_busy"}, bc, e.busy);
    chk({nm, "_hi"}, bus.hi, e.hi);
    chk({nm, "_lo"}, bus.lo, e.lo);
    chk({nm, "_dbz"}, bus.div_by_zero, e.dbz);
  endtask

  vec_t tbl[10];

  initial begin
    int dn, bz;
    exp_t e;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    n_pass = 0; n_tot = 0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.flush = 1'b0;

    tbl[0] = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33};
    tbl[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33};
    tbl[2] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34, 33};
    tbl[3] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33};
    tbl[4] = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34, 33};
    tbl[5] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33};
    tbl[6] = '{DIVU,  32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 34, 33};
    tbl[7] = '{DIV,   32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 2, 1};
    tbl[8] = '{MULT,  32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 34, 33};
    tbl[9] = '{DIVU,  32'h00000009, 32'h00000000, 32'h00000000, 32'h0000000F, 1'b1, 2, 1};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table: each op is issued in the done cycle of the previous one,
    // so every entry after the first also exercises back-to-back issue.
    for (int i = 0; i < 10; i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dbz = tbl[i].dbz;
      e.lat = tbl[i].lat; e.busy = tbl[i].busy;
      sb_q.push_back(e);
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done($sformatf("vec%0d", i));
    end

    // Second start at counter 5 is ignored; flush at counter 10 aborts.
    // Pre-op state: hi=0, lo=0xF, div_by_zero=1.
    issue(MULT, 32'd2, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", bus.busy, 0);
    dn = 0; bz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.busy) bz++;
    end
    chk("flush_no_done", dn, 0);
    chk("flush_stays_idle", bz, 0);
    chk("flush_hi", bus.hi, 32'h0);
    chk("flush_lo", bus.lo, 32'hF);
    chk("flush_dbz", bus.div_by_zero, 1);

    // Flush and start together in IDLE: start is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MULT; bus.a = 32'd4; bus.b = 32'd4;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    chk("flush_start_busy", bus.busy, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("flush_start_no_done", dn, 0);
    chk("flush_start_lo", bus.lo, 32'hF);

    // Asynchronous reset mid-RUN clears outputs before any clock edge.
    issue(MULT, 32'd5, 32'd6);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_dbz", bus.div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);

    // Random ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 5) begin rop = DIV; rb = 32'h0; end
      e = model(rop, ra, rb, mhi, mlo);
      mhi = e.hi; mlo = e.lo;
      sb_q.push_back(e);
      issue(rop, ra, rb);
      wait_done($sformatf("rnd%0d", i));
    end

    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
